rs_bank: RTL
============

# rs_bank

Parametrised out-of-order reservation-station bank between dispatch and an execution unit. Holds up to RS_DEPTH in-flight instructions tagged by ROB index, wakes operands from NUM_CDB result-broadcast ports, and issues the oldest ready entry through a valid/ready handshake. Adds age-ordered issue, multi-port CDB wakeup, dispatch-cycle CDB bypass and back-pressure beyond the fixed 8-entry, single-CDB station.

## Interface
- RS_DEPTH, 8: entry count, ≥2.
- NUM_CDB, 2: CDB broadcast ports, ≥1.
- TAG_W, 5: ROB tag width (clog2 of ROB_SIZE).
- XLEN, 32: operand width.
- PAYLOAD_W, 64: opaque decoded-control payload (inst, PC, NPC, alu_func, selects, flags).
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  branch-mispredict squash; empties the bank.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  bank can accept; =!full.
- disp_tag  in  TAG_W  ROB tag of the dispatched instruction.
- disp_src_rdy  in  2  per-source operand already valid.
- disp_src_tag  in  2×TAG_W  producer tag for non-ready sources.
- disp_src_val  in  2×XLEN  operand value for ready sources.
- disp_payload  in  PAYLOAD_W  passed through unchanged.
- cdb_valid  in  NUM_CDB  broadcast valid per port.
- cdb_tag  in  NUM_CDB×TAG_W  broadcast tag.
- cdb_value  in  NUM_CDB×XLEN  broadcast value.
- iss_valid  out  1  an entry is ready to issue.
- iss_ready  in  1  execution unit accepts.
- iss_tag, iss_src_val, iss_payload  out  TAG_W / 2×XLEN / PAYLOAD_W  selected entry contents.
- free_count  out  clog2(RS_DEPTH+1)  free entries.
- empty  out  1  no valid entries.

## Operation
- Entry state: valid, tag, src_rdy[2], src_tag[2], src_val[2], payload; age matrix older[i][j].
- Dispatch fire = disp_valid && disp_ready && !flush. Allocates lowest-index free entry; sets older[k][j]=0 for all j, older[j][k]=1 for every valid j that is not leaving this cycle.
- Dispatch bypass: non-ready source whose src_tag matches an asserting CDB port in the same cycle is written ready with that port's value.
- Wakeup: each valid, non-ready source compares against all CDB ports each cycle; on match sets src_rdy and captures value. Multiple ports matching: lowest port index wins.
- Issue: candidate = valid && both src_rdy. Selected = candidate i with no candidate j where older[j][i]. iss_valid = any candidate && !flush. Outputs show selected entry combinationally from registers. Issue fire = iss_valid && iss_ready frees that entry at the clock edge.
- Outputs must hold stable while iss_valid && !iss_ready unless an older entry becomes ready (re-selection allowed; consumer samples only on fire).
- Flush: all valid bits clear at the edge; priority over dispatch, wakeup, issue. disp_ready and iss_valid remain as computed from state except iss_valid forced 0 during flush.

## Timing
- Reset: all entries invalid, age matrix 0, disp_ready=1, iss_valid=0, free_count=RS_DEPTH, empty=1; iss_* outputs 0.
- Dispatch at edge t with both sources ready → iss_valid in cycle t+1 (one-cycle minimum latency); never issues in dispatch cycle.
- CDB match in cycle t → entry eligible in cycle t+1.
- Full: disp_ready=0 even if issue fires same cycle (no same-cycle free-to-allocate bypass).
- Dispatch and issue in the same cycle both complete; free_count unchanged.
- Reset or flush mid-handshake: pending iss_valid dropped, no entry survives.

## Structure
- Shared package rs_pkg: rs_entry_t struct, parameter defaults, tag typedef.
- Sub-module rs_oldest_select: age-matrix oldest-ready selector producing one-hot grant and valid; reused by the allocator's lowest-free encoder pattern.
- Top holds entry array, age matrix update, CDB compare, free counting.

## Test plan
- Reset, dispatch tag 3 with both sources ready (0x11, 0x22), iss_ready=1 → next cycle iss_valid=1, iss_tag=3, values 0x11/0x22; free_count returns 8.
- Dispatch tags 1,2,3 with src1 waiting on tag 9; broadcast tag 9 value 0xABCD on port 1 → all three ready next cycle; issue order 1,2,3 on consecutive cycles.
- Fill 8 entries, none ready → disp_ready=0, free_count=0; extra disp_valid ignored; one wakeup+issue → disp_ready=1 the following cycle.
- Dispatch source tag 7 in same cycle CDB port 0 broadcasts tag 7 value 0x55 → entry ready next cycle, iss_src_val=0x55.
- Hold iss_ready=0 with ready entry tag 4 for 3 cycles → iss_tag=4 steady, entry retained; release → freed.
- 5 valid entries, assert flush with disp_valid=1 → next cycle empty=1, free_count=8, no issue.

Source files
------------

// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_pkg
// Description : Shared types and default sizing for the reservation-station
//               bank and its selector.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

    // Default bank geometry; rs_bank parameters take these as defaults.
    localparam int RS_DEPTH_DEF  = 8;
    localparam int NUM_CDB_DEF   = 2;
    localparam int TAG_W_DEF     = 5;
    localparam int XLEN_DEF      = 32;
    localparam int PAYLOAD_W_DEF = 64;

    // ROB tag at the default width.
    typedef logic [TAG_W_DEF-1:0] rs_tag_t;

    // One station entry at the default geometry. rs_bank declares the same
    // layout locally, sized by its own parameters.
    typedef struct packed {
        logic                              valid;
        rs_tag_t                           tag;
        logic [1:0]                        src_rdy;
        logic [1:0][TAG_W_DEF-1:0]         src_tag;
        logic [1:0][XLEN_DEF-1:0]          src_val;
        logic [PAYLOAD_W_DEF-1:0]          payload;
    } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/rs_oldest_select.sv
`default_nettype none
// ============================================================================
// Module      : rs_oldest_select
// Description : Grants the requester that no other requester is older than.
//               older_i[j*N+i] = 1 means j is older than i. With a strict
//               "j < i" matrix it becomes a lowest-index priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_oldest_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]   req_i,
    input  logic [N*N-1:0] older_i,
    output logic [N-1:0]   grant_o,
    output logic           valid_o
);

    // Column i of the matrix: which entries are older than entry i.
    logic [N-1:0] older_than [N];

    generate
        for (genvar i = 0; i < N; i++) begin : g_grant
            for (genvar j = 0; j < N; j++) begin : g_col
                assign older_than[i][j] = older_i[j*N+i];
            end
            // Blocked if any older entry is also requesting.
            assign grant_o[i] = req_i[i] && !(|(req_i & older_than[i]));
        end
    endgenerate

    assign valid_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/rs_bank.sv
`default_nettype none
// ============================================================================
// Module      : rs_bank
// Description : Out-of-order reservation-station bank. Captures dispatched
//               instructions, wakes operands from multiple CDB ports
//               (including same-cycle dispatch bypass) and issues the oldest
//               ready entry through a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_bank
    import rs_pkg::*;
#(
    parameter int RS_DEPTH  = RS_DEPTH_DEF,
    parameter int NUM_CDB   = NUM_CDB_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int XLEN      = XLEN_DEF,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          disp_valid,
    output logic                          disp_ready,
    input  logic [TAG_W-1:0]              disp_tag,
    input  logic [1:0]                    disp_src_rdy,
    input  logic [2*TAG_W-1:0]            disp_src_tag,
    input  logic [2*XLEN-1:0]             disp_src_val,
    input  logic [PAYLOAD_W-1:0]          disp_payload,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]       cdb_value,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [TAG_W-1:0]              iss_tag,
    output logic [2*XLEN-1:0]             iss_src_val,
    output logic [PAYLOAD_W-1:0]          iss_payload,
    output logic [$clog2(RS_DEPTH+1)-1:0] free_count,
    output logic                          empty
);

    localparam int FC_W = $clog2(RS_DEPTH+1);

    typedef struct packed {
        logic                      valid;
        logic [TAG_W-1:0]          tag;
        logic [1:0]                src_rdy;
        logic [1:0][TAG_W-1:0]     src_tag;
        logic [1:0][XLEN-1:0]      src_val;
        logic [PAYLOAD_W-1:0]      payload;
    } entry_t;

    entry_t                         entry_q [RS_DEPTH];
    entry_t                         entry_d [RS_DEPTH];
    // older_q[j*RS_DEPTH+i] = 1 when entry j was dispatched before entry i.
    logic [RS_DEPTH*RS_DEPTH-1:0]   older_q;
    logic [RS_DEPTH*RS_DEPTH-1:0]   older_d;
    logic [RS_DEPTH*RS_DEPTH-1:0]   low_first;

    logic [RS_DEPTH-1:0] valid_vec;
    logic [RS_DEPTH-1:0] cand_vec;
    logic [RS_DEPTH-1:0] iss_grant;
    logic [RS_DEPTH-1:0] alloc_grant;
    logic                iss_any;
    logic                alloc_any;
    logic                disp_fire;
    logic                iss_fire;
    logic [FC_W-1:0]     used_cnt;

    generate
        for (genvar i = 0; i < RS_DEPTH; i++) begin : g_vec
            assign valid_vec[i] = entry_q[i].valid;
            assign cand_vec[i]  = entry_q[i].valid && (&entry_q[i].src_rdy);
        end
        // Fixed priority "lower index beats higher" for the allocator.
        for (genvar j = 0; j < RS_DEPTH; j++) begin : g_prio_row
            for (genvar i = 0; i < RS_DEPTH; i++) begin : g_prio_col
                assign low_first[j*RS_DEPTH+i] = (j < i) ? 1'b1 : 1'b0;
            end
        end
    endgenerate

    rs_oldest_select #(.N(RS_DEPTH)) u_issue_sel (
        .req_i   (cand_vec),
        .older_i (older_q),
        .grant_o (iss_grant),
        .valid_o (iss_any)
    );

    rs_oldest_select #(.N(RS_DEPTH)) u_alloc_sel (
        .req_i   (~valid_vec),
        .older_i (low_first),
        .grant_o (alloc_grant),
        .valid_o (alloc_any)
    );

    // A free slot exists only if some entry is invalid now; issue this cycle
    // does not open a slot for same-cycle dispatch.
    assign disp_ready = alloc_any;
    assign disp_fire  = disp_valid && alloc_any && !flush;
    assign iss_valid  = iss_any && !flush;
    assign iss_fire   = iss_valid && iss_ready;
    assign empty      = ~|valid_vec;

    // Selected-entry output mux (one-hot OR); all zero when nothing is ready.
    always_comb begin
        iss_tag     = '0;
        iss_src_val = '0;
        iss_payload = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (iss_grant[i]) begin
                iss_tag     = iss_tag     | entry_q[i].tag;
                iss_src_val = iss_src_val | entry_q[i].src_val;
                iss_payload = iss_payload | entry_q[i].payload;
            end
        end
    end

    // Occupancy count for free_count.
    always_comb begin
        used_cnt = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            used_cnt = used_cnt + FC_W'(valid_vec[i]);
        end
    end

    assign free_count = FC_W'(RS_DEPTH) - used_cnt;

    // Next-state: wakeup, issue release, dispatch allocate, then flush.
    always_comb begin
        entry_d = entry_q;
        older_d = older_q;

        // CDB wakeup; descending scan so the lowest matching port wins.
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (entry_q[i].valid && !entry_q[i].src_rdy[s]) begin
                    for (int p = NUM_CDB-1; p >= 0; p--) begin
                        if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == entry_q[i].src_tag[s])) begin
                            entry_d[i].src_rdy[s] = 1'b1;
                            entry_d[i].src_val[s] = cdb_value[p*XLEN +: XLEN];
                        end
                    end
                end
            end
        end

        // Issued entry leaves at this edge.
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (iss_fire && iss_grant[i]) begin
                entry_d[i].valid = 1'b0;
            end
        end

        // Dispatch into the lowest free slot, with same-cycle CDB bypass.
        for (int k = 0; k < RS_DEPTH; k++) begin
            if (disp_fire && alloc_grant[k]) begin
                entry_d[k].valid   = 1'b1;
                entry_d[k].tag     = disp_tag;
                entry_d[k].payload = disp_payload;
                for (int s = 0; s < 2; s++) begin
                    entry_d[k].src_tag[s] = disp_src_tag[s*TAG_W +: TAG_W];
                    entry_d[k].src_rdy[s] = disp_src_rdy[s];
                    entry_d[k].src_val[s] = disp_src_rdy[s] ? disp_src_val[s*XLEN +: XLEN] : '0;
                    if (!disp_src_rdy[s]) begin
                        for (int p = NUM_CDB-1; p >= 0; p--) begin
                            if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == disp_src_tag[s*TAG_W +: TAG_W])) begin
                                entry_d[k].src_rdy[s] = 1'b1;
                                entry_d[k].src_val[s] = cdb_value[p*XLEN +: XLEN];
                            end
                        end
                    end
                end
                // New entry is younger than every entry that stays.
                for (int j = 0; j < RS_DEPTH; j++) begin
                    older_d[k*RS_DEPTH+j] = 1'b0;
                    older_d[j*RS_DEPTH+k] = valid_vec[j] && !(iss_fire && iss_grant[j]);
                end
            end
        end

        // Squash overrides everything else.
        if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_d[i].valid = 1'b0;
            end
            older_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            older_q <= '0;
        end else begin
            entry_q <= entry_d;
            older_q <= older_d;
        end
    end

endmodule
`default_nettype wire
